// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for the pet action controller.
//   - pet_state_e : controller FSM states
//   - ACT_*       : action index of each care action on the actions bus
//   - ACT_W       : width of the actions bus driving the stats block
//   - act_onehot  : one-hot pulse pattern for a selected action index
package pet_pkg;

  localparam int ACT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BROWSE   = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } pet_state_e;

  localparam logic [2:0] ACT_FEED     = 3'd0;  // hunger
  localparam logic [2:0] ACT_PLAY     = 3'd1;  // happiness
  localparam logic [2:0] ACT_MEDICINE = 3'd2;  // health
  localparam logic [2:0] ACT_CLEAN    = 3'd3;  // hygiene
  localparam logic [2:0] ACT_SLEEP    = 3'd4;  // energy
  localparam logic [2:0] ACT_VISIT    = 3'd5;  // social

  // Bits at or above num_actions are never set, so unused bus lanes stay 0.
  function automatic logic [ACT_W-1:0] act_onehot(input logic [2:0] idx,
                                                  input int num_actions);
    logic [ACT_W-1:0] v;
    v = {ACT_W{1'b0}};
    for (int i = 0; i < ACT_W; i++) begin
      if ((i < num_actions) && (idx == 3'(i))) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one asynchronous raw button into a clean press pulse.
//   clk, reset : clock, asynchronous active-high reset
//   raw        : asynchronous raw button level
//   press      : one-cycle pulse on each accepted rising edge of the level
// Path: 2-flop synchronizer -> counting debouncer -> registered rise detector.
// The pulse follows the first sampling edge by DEBOUNCE_CYCLES+2 cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_q;
  logic          press_d;

  // Debounce counter and rise detection: a differing sample counts, an agreeing one clears.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d   = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    press_d = level_q & ~level_prev_q;
  end

  // Synchronizer, debounced level, counter and pulse flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pet_action_ctrl.sv
// pet_action_ctrl: three-button menu controller that fires care actions.
//   clk, reset      : clock, asynchronous active-high reset
//   btn_*_raw       : asynchronous raw select / confirm / cancel buttons
//   actions[7:0]    : one-cycle one-hot action pulse to the stats block
//   menu_sel[2:0]   : highlighted action index
//   menu_active     : high while browsing the menu
//   busy            : high while an action fires and during its lockout
// All outputs are flops; the registered outputs are loaded from the next state
// so a press seen in cycle n produces the action pulse in cycle n+1.
module pet_action_ctrl
  import pet_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 64,
  parameter int BROWSE_TIMEOUT  = 1000,
  parameter int NUM_ACTIONS     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_select_raw,
  input  logic             btn_confirm_raw,
  input  logic             btn_cancel_raw,
  output logic [ACT_W-1:0] actions,
  output logic [2:0]       menu_sel,
  output logic             menu_active,
  output logic             busy
);

  localparam int TW  = $clog2(BROWSE_TIMEOUT + 1);
  localparam int CCW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(BROWSE_TIMEOUT - 1);
  localparam logic [CCW-1:0] COOL_LAST = CCW'(COOLDOWN_CYCLES - 1);
  localparam logic [2:0]     SEL_LAST  = 3'(NUM_ACTIONS - 1);

  logic sel_press;
  logic conf_press;
  logic canc_press;

  pet_state_e       state_q;
  pet_state_e       state_d;
  logic [2:0]       menu_sel_q;
  logic [2:0]       menu_sel_d;
  logic [TW-1:0]    tmo_q;
  logic [TW-1:0]    tmo_d;
  logic [CCW-1:0]   cool_q;
  logic [CCW-1:0]   cool_d;
  logic [ACT_W-1:0] actions_q;
  logic [ACT_W-1:0] actions_d;
  logic             menu_active_q;
  logic             menu_active_d;
  logic             busy_q;
  logic             busy_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
    .clk(clk), .reset(reset), .raw(btn_select_raw), .press(sel_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk(clk), .reset(reset), .raw(btn_confirm_raw), .press(conf_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk(clk), .reset(reset), .raw(btn_cancel_raw), .press(canc_press)
  );

  // State, counters, selection and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      menu_sel_q    <= 3'd0;
      tmo_q         <= {TW{1'b0}};
      cool_q        <= {CCW{1'b0}};
      actions_q     <= {ACT_W{1'b0}};
      menu_active_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      menu_sel_q    <= menu_sel_d;
      tmo_q         <= tmo_d;
      cool_q        <= cool_d;
      actions_q     <= actions_d;
      menu_active_q <= menu_active_d;
      busy_q        <= busy_d;
    end
  end

  // Next state; counters default to 0 so they restart on every entry and press.
  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    tmo_d      = {TW{1'b0}};
    cool_d     = {CCW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (sel_press) begin
          state_d = ST_BROWSE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BROWSE: begin
        if (canc_press) begin
          state_d = ST_IDLE;
        end else if (conf_press) begin
          state_d = ST_FIRE;
        end else if (sel_press) begin
          if (menu_sel_q >= SEL_LAST) begin
            menu_sel_d = 3'd0;
          end else begin
            menu_sel_d = menu_sel_q + 3'd1;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1'b1);
        end
      end
      ST_FIRE: begin
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        // Presses are simply not looked at here, so none are queued.
        if (cool_q >= COOL_LAST) begin
          state_d = ST_BROWSE;
        end else begin
          cool_d = cool_q + CCW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    actions_d     = {ACT_W{1'b0}};
    menu_active_d = 1'b0;
    busy_d        = 1'b0;
    case (state_d)
      ST_BROWSE: begin
        menu_active_d = 1'b1;
      end
      ST_FIRE: begin
        actions_d = act_onehot(menu_sel_q, NUM_ACTIONS);
        busy_d    = 1'b1;
      end
      ST_COOLDOWN: begin
        busy_d = 1'b1;
      end
      default: begin
        menu_active_d = 1'b0;
      end
    endcase
  end

  assign actions     = actions_q;
  assign menu_sel    = menu_sel_q;
  assign menu_active = menu_active_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pet_action_ctrl.sv
// Bench for pet_action_ctrl: directed scenarios with literal expectations plus
// randomized button activity, all checked against a behavioural model.
module tb_pet_action_ctrl;

  localparam int D  = 4;
  localparam int C  = 8;
  localparam int T  = 20;
  localparam int NA = 6;

  localparam int S_IDLE   = 0;
  localparam int S_BROWSE = 1;
  localparam int S_FIRE   = 2;
  localparam int S_COOL   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_sel = 1'b0;
  logic       btn_conf = 1'b0;
  logic       btn_canc = 1'b0;
  logic [7:0] actions;
  logic [2:0] menu_sel;
  logic       menu_active;
  logic       busy;

  int total = 0;
  int bad   = 0;

  pet_action_ctrl #(
    .DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C), .BROWSE_TIMEOUT(T), .NUM_ACTIONS(NA)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_select_raw(btn_sel), .btn_confirm_raw(btn_conf), .btn_cancel_raw(btn_canc),
    .actions(actions), .menu_sel(menu_sel), .menu_active(menu_active), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // History of raw samples {cancel,confirm,select} per clock edge since reset
  // and the debounced level after each edge.
  bit [2:0] rawq[$];
  bit [2:0] lvlq[$];
  bit [2:0] vis = 3'b000;   // presses visible in the current cycle
  int       mst = S_IDLE;
  int       msel = 0;
  int       idle_n = 0;
  int       cool_n = 0;
  logic [7:0] exp_act = 8'h00;
  logic [2:0] exp_sel = 3'd0;
  logic       exp_act_m = 1'b0;
  logic       exp_busy = 1'b0;

  int       e;
  bit [2:0] pr;
  bit [2:0] cur;
  bit [2:0] nl;
  bit       flip;
  logic [7:0] one8;

  initial begin : model
    forever begin
      @(posedge clk);
      if (reset) begin
        rawq.delete();
        lvlq.delete();
        vis = 3'b000;
        mst = S_IDLE; msel = 0; idle_n = 0; cool_n = 0;
      end else begin
        e  = rawq.size();
        pr = vis;
        rawq.push_back({btn_canc, btn_conf, btn_sel});
        cur = (e >= 1) ? lvlq[e-1] : 3'b000;
        nl  = cur;
        // Level flips when the last D synchronized samples all disagree with it;
        // the sample used at edge x is the raw value taken at edge x-2.
        for (int b = 0; b < 3; b++) begin
          flip = 1'b1;
          for (int k = 0; k < D; k++) begin
            if (e - k < 2) flip = 1'b0;
            else if (rawq[e-k-2][b] == cur[b]) flip = 1'b0;
          end
          if (flip) nl[b] = ~cur[b];
        end
        lvlq.push_back(nl);
        // A press is visible one cycle after the edge at which the level rose.
        vis = cur & ~((e >= 2) ? lvlq[e-2] : 3'b000);
        case (mst)
          S_IDLE: if (pr[0]) begin mst = S_BROWSE; idle_n = 0; end
          S_BROWSE: begin
            if (pr[2]) mst = S_IDLE;
            else if (pr[1]) mst = S_FIRE;
            else if (pr[0]) begin msel = (msel + 1) % NA; idle_n = 0; end
            else begin
              idle_n++;
              if (idle_n == T) mst = S_IDLE;
            end
          end
          S_FIRE: begin mst = S_COOL; cool_n = C; end
          default: begin
            cool_n--;
            if (cool_n == 0) begin mst = S_BROWSE; idle_n = 0; end
          end
        endcase
      end
      one8      = 8'h01 << msel;
      exp_act   = (mst == S_FIRE) ? one8 : 8'h00;
      exp_sel   = 3'(msel);
      exp_act_m = (mst == S_BROWSE);
      exp_busy  = (mst == S_FIRE) || (mst == S_COOL);
    end
  end

  // Every-cycle comparison against the model, well after the active edge.
  initial begin : compare
    forever begin
      @(posedge clk);
      #2;
      chk("m_actions", {24'd0, actions}, {24'd0, exp_act});
      chk("m_menu_sel", {29'd0, menu_sel}, {29'd0, exp_sel});
      chk("m_menu_active", {31'd0, menu_active}, {31'd0, exp_act_m});
      chk("m_busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  // ---------------- stimulus ----------------
  task automatic press_btn(input int b);
    if (b == 0) btn_sel = 1'b1; else if (b == 1) btn_conf = 1'b1; else btn_canc = 1'b1;
    tick(8);
    if (b == 0) btn_sel = 1'b0; else if (b == 1) btn_conf = 1'b0; else btn_canc = 1'b0;
    tick(7);
  endtask

  int wrap_exp[6] = '{1, 2, 3, 4, 5, 0};
  int npulse;
  int nbusy;
  int nact;
  int run[3];

  initial begin : stim
    tick(3);
    chk("reset_actions", {24'd0, actions}, 32'h0);
    chk("reset_outs", {28'd0, menu_sel, menu_active}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Bounce: 2-cycle runs never reach the debounce threshold.
    for (int i = 0; i < 3; i++) begin
      btn_sel = 1'b1; tick(2);
      btn_sel = 1'b0; tick(2);
    end
    tick(10);
    chk("bounce_idle", {31'd0, menu_active}, 32'h0);

    // First select press: BROWSE becomes visible exactly 8 negedges after raise.
    btn_sel = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) chk("lat_before", {31'd0, menu_active}, 32'h0);
      if (i == 8) chk("lat_browse", {31'd0, menu_active}, 32'h1);
    end
    btn_sel = 1'b0;
    tick(7);
    chk("enter_sel", {29'd0, menu_sel}, 32'h0);

    // Menu wrap.
    for (int i = 0; i < 6; i++) begin
      press_btn(0);
      chk("wrap_sel", {29'd0, menu_sel}, 32'(wrap_exp[i]));
    end
    chk("wrap_active", {31'd0, menu_active}, 32'h1);
    press_btn(0);
    press_btn(0);
    chk("sel_two", {29'd0, menu_sel}, 32'h2);

    // Fire with a second confirm press landing inside the cooldown.
    npulse = 0; nbusy = 0;
    btn_conf = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5)  btn_conf = 1'b0;
      if (i == 9)  btn_conf = 1'b1;
      if (i == 13) btn_conf = 1'b0;
      tick(1);
      if (actions != 8'h00) npulse++;
      if (busy) nbusy++;
      if (i == 8) chk("fire_pulse", {24'd0, actions}, 32'h04);
    end
    chk("fire_count", 32'(npulse), 32'd1);
    chk("busy_len", 32'(nbusy), 32'd9);
    chk("after_cool", {31'd0, menu_active}, 32'h1);

    // Cancel and confirm together in BROWSE: cancel wins, nothing fires.
    press_btn(0);
    nact = 0;
    btn_canc = 1'b1; btn_conf = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 8) begin btn_canc = 1'b0; btn_conf = 1'b0; end
      tick(1);
      if (actions != 8'h00) nact++;
    end
    chk("prio_no_act", 32'(nact), 32'd0);
    chk("prio_idle", {31'd0, menu_active}, 32'h0);

    // Timeout: BROWSE lasts T idle cycles, selection kept.
    nact = 0;
    btn_sel = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 9) btn_sel = 1'b0;
      tick(1);
      if (menu_active) nact++;
    end
    chk("tmo_len", 32'(nact), 32'd20);
    chk("tmo_sel", {29'd0, menu_sel}, 32'h3);

    // Reset during COOLDOWN with select held through reset.
    press_btn(0);
    btn_conf = 1'b1;
    tick(8);
    chk("pre_rst_fire", {24'd0, actions}, 32'h08);
    btn_conf = 1'b0;
    tick(3);
    btn_sel = 1'b1;
    tick(1);
    reset = 1'b1;
    #1;
    chk("rst_async", {actions, menu_sel, menu_active, busy}, 32'h0);
    tick(3);
    chk("rst_hold", {actions, menu_sel, menu_active, busy}, 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) chk("rel_before", {31'd0, menu_active}, 32'h0);
      if (i == 8) chk("rel_browse", {31'd0, menu_active}, 32'h1);
    end
    btn_sel = 1'b0;
    tick(10);

    // Random button activity with occasional resets.
    for (int b = 0; b < 3; b++) run[b] = $urandom_range(1, 14);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < 3; b++) begin
        run[b]--;
        if (run[b] <= 0) begin
          run[b] = $urandom_range(1, 14);
          if (b == 0) btn_sel = ~btn_sel;
          else if (b == 1) btn_conf = ~btn_conf;
          else btn_canc = ~btn_canc;
        end
      end
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
